// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic logic [BCD_DIGIT_W-1:0] nines_digit(input logic [BCD_DIGIT_W-1:0] d);
    return 4'd9 - d;
  endfunction

  // True when DIGITS decimal digits can hold every BIN_W-bit unsigned value.
  function automatic bit range_ok(input int unsigned bin_w, input int unsigned digits);
    longint unsigned p10;
    longint unsigned lim;
    if (bin_w >= 63) return 1'b0;
    lim = 64'd1 << bin_w;
    p10 = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      if (p10 >= lim) break;
      p10 = p10 * 64'd10;
    end
    return p10 >= lim;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= ADJ_THRESH) begin
      adjusted = digit + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with valid/ready on both sides.
// Optional registered per-digit 9's complement output: define BIN_TO_BCD_NINES_COMP_EN.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          busy
`ifdef BIN_TO_BCD_NINES_COMP_EN
  ,
  output logic [BCD_DIGIT_W*DIGITS-1:0] nines_out
`endif
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (!range_ok(BIN_W, DIGITS)) begin : gen_param_err
    $error("bin_to_bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   bin_q, bin_sh;
  logic [BCD_W-1:0]   work_q, work_adj, work_sh;
  logic [BCD_W-1:0]   bcd_q;
  logic               last_shift;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign last_shift = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:  in_ready = 1'b1;
      SHIFT: busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: correct all digits from the pre-shift value, then shift {bcd, bin} left
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DIGITS; i++) begin : gen_add3
    bcd_add3 u_add3 (
      .digit    (work_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .adjusted (work_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    {work_sh, bin_sh} = {work_adj, bin_q} << 1;
  end

`ifdef BIN_TO_BCD_NINES_COMP_EN
  logic [BCD_W-1:0] nines_q, nines_sh;

  always_comb begin
    nines_sh = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nines_sh[BCD_DIGIT_W*i +: BCD_DIGIT_W] = nines_digit(work_sh[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nines_q <= '0;
    end else if (state_q == SHIFT && last_shift) begin
      nines_q <= nines_sh;
    end
  end

  assign nines_out = nines_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bin_q  <= '0;
      work_q <= '0;
      bcd_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q  <= bin_in;
            work_q <= '0;
            cnt_q  <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          bin_q  <= bin_sh;
          work_q <= work_sh;
          cnt_q  <= cnt_q - CNT_W'(1);
          // The result register only changes on the edge that enters DONE.
          if (last_shift) begin
            bcd_q <= work_sh;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, exhaustive sweep via scoreboard,
// and hand-written handshake/reset corner cases.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd_out;
  logic        busy;
`ifdef BIN_TO_BCD_NINES_COMP_EN
  logic [11:0] nines_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] sb[$];

  bin_to_bcd_seq #(
    .BIN_W  (8),
    .DIGITS (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .busy      (busy)
`ifdef BIN_TO_BCD_NINES_COMP_EN
    ,
    .nines_out (nines_out)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push at the cycle an accept will happen, pop on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(ref_bcd(int'(bin_in)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got %0h expected no output", bcd_out);
        end else begin
          logic [11:0] e;
          e = sb.pop_front();
          check("sb_bcd", 32'(bcd_out), 32'(e));
`ifdef BIN_TO_BCD_NINES_COMP_EN
          check("sb_nines", 32'(nines_out), 32'(12'h999 - e));
`endif
        end
      end
    end
  end

  // Present v, wait for accept, then count cycles until out_valid (does not consume it).
  task automatic convert(input logic [7:0] v, output int lat);
    int guard;
    in_valid = 1'b1;
    bin_in   = v;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    bin_in   = 8'hA5;
    lat      = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (lat >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no out_valid expected within 50 cycles for %0d", v);
    end
  endtask

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [11:0] nines;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int k;
    int acc[3];
    logic [7:0] vals[3];

    vecs[0] = '{bin: 8'd0,   bcd: 12'h000, nines: 12'h999};
    vecs[1] = '{bin: 8'd255, bcd: 12'h255, nines: 12'h744};
    vecs[2] = '{bin: 8'd9,   bcd: 12'h009, nines: 12'h990};
    vecs[3] = '{bin: 8'd123, bcd: 12'h123, nines: 12'h876};
    vecs[4] = '{bin: 8'd100, bcd: 12'h100, nines: 12'h899};
    vecs[5] = '{bin: 8'd99,  bcd: 12'h099, nines: 12'h900};
    vals[0] = 8'd11;
    vals[1] = 8'd22;
    vals[2] = 8'd33;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bin_in    = 8'd0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
`ifdef BIN_TO_BCD_NINES_COMP_EN
    check("rst_nines", 32'(nines_out), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Vector table with latency and direct output checks
    foreach (vecs[i]) begin
      convert(vecs[i].bin, lat);
      check("vec_latency", 32'(lat), 32'd8);
      check("vec_bcd", 32'(bcd_out), 32'(vecs[i].bcd));
      check("vec_busy_done", 32'(busy), 32'd1);
`ifdef BIN_TO_BCD_NINES_COMP_EN
      check("vec_nines", 32'(nines_out), 32'(vecs[i].nines));
`endif
      tick();
      check("vec_back_idle", 32'(in_ready), 32'd1);
    end

    // Exhaustive sweep, checked by the scoreboard
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), lat);
      tick();
    end

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    convert(8'd123, lat);
    for (int c = 0; c < 5; c++) begin
      check("bp_bcd", 32'(bcd_out), 32'h123);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_out_valid_drop", 32'(out_valid), 32'd0);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    check("bp_bcd_held", 32'(bcd_out), 32'h123);

    // in_valid during SHIFT is ignored
    in_valid = 1'b1;
    bin_in   = 8'd42;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("ign_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    bin_in   = 8'd77;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("ign_bcd", 32'(bcd_out), 32'h042);
    tick();
    for (int c = 0; c < 12; c++) tick();
    check("ign_no_second", 32'(out_valid), 32'd0);
    check("ign_bcd_held", 32'(bcd_out), 32'h042);

    // Reset mid-SHIFT aborts the conversion
    in_valid = 1'b1;
    bin_in   = 8'd150;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bcd", 32'(bcd_out), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    convert(8'd200, lat);
    check("post_rst_latency", 32'(lat), 32'd8);
    check("post_rst_bcd", 32'(bcd_out), 32'h200);
    tick();

    // Back-to-back with in_valid held: one accept every 10 cycles
    in_valid = 1'b1;
    bin_in   = vals[0];
    k = 0;
    for (int c = 0; c < 60 && k < 3; c++) begin
      if (in_ready) begin
        acc[k] = c;
        k++;
      end
      tick();
      if (k < 3) bin_in = vals[k];
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    tick();
    check("b2b_accepts", 32'(k), 32'd3);
    if (k == 3) begin
      check("b2b_ii_1", 32'(acc[1] - acc[0]), 32'd10);
      check("b2b_ii_2", 32'(acc[2] - acc[1]), 32'd10);
    end
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
